// File: rtl/coord_mem_arbiter.sv
// Shares the single-port coordinate RAM between a writer (collector) and a reader (pathfinder).
// Latency: write acks 1 cycle after grant; rd_valid RD_LAT+1 cycles after rd_ack (1 cycle if out of range).
// Backpressure: requests are held until acked; reads stall indefinitely while table_ready is low.
module coord_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              coll_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_x,
    input  logic [DATA_W-1:0] wr_y,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_x,
    output logic [DATA_W-1:0] rd_y,
    output logic              rd_err,
    output logic              table_ready,
    output logic [ADDR_W:0]   coord_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_x_d,
    output logic [DATA_W-1:0] mem_y_d,
    input  logic [DATA_W-1:0] mem_x_q,
    input  logic [DATA_W-1:0] mem_y_q
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RD_DONE = 3'd4;

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);

    logic [2:0]    state;
    logic          last_grant;  // 1 = last grant went to the reader
    logic          rd_oor;
    logic          rd_err_r;
    logic [CW-1:0] wait_cnt;

    logic          grant_wr;
    logic          grant_rd;
    logic          rd_elig;
    logic          rd_in_range;
    logic [ADDR_W:0] wr_top;

    always_comb begin
        rd_elig     = rd_req & table_ready;
        grant_wr    = wr_req & (~rd_elig | last_grant);
        grant_rd    = rd_elig & (~wr_req | ~last_grant);
        rd_in_range = ({1'b0, rd_addr} < coord_count);
        wr_top      = {1'b0, mem_addr} + (ADDR_W+1)'(1);
    end

    assign mem_wren = (state == S_WRITE);
    assign wr_ack   = (state == S_WRITE);
    assign rd_ack   = (state == S_READ);
    assign rd_valid = (state == S_RD_DONE);
    assign rd_err   = rd_valid & rd_err_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            rd_oor      <= 1'b0;
            rd_err_r    <= 1'b0;
            wait_cnt    <= '0;
            table_ready <= 1'b0;
            coord_count <= '0;
            mem_addr    <= '0;
            mem_x_d     <= '0;
            mem_y_d     <= '0;
            rd_x        <= '0;
            rd_y        <= '0;
        end else begin
            if (clear)
                table_ready <= 1'b0;
            else if (coll_done)
                table_ready <= 1'b1;

            // The RAM write of a WRITE cycle still happens under clear, since mem_wren is state-decoded.
            if (clear) begin
                state       <= S_IDLE;
                coord_count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (grant_wr) begin
                            state      <= S_WRITE;
                            last_grant <= 1'b0;
                            mem_addr   <= wr_addr;
                            mem_x_d    <= wr_x;
                            mem_y_d    <= wr_y;
                        end else if (grant_rd) begin
                            state      <= S_READ;
                            last_grant <= 1'b1;
                            rd_oor     <= ~rd_in_range;
                            if (rd_in_range)
                                mem_addr <= rd_addr;
                        end
                    end
                    S_WRITE: begin
                        if (wr_top > coord_count)
                            coord_count <= wr_top;
                        state <= S_IDLE;
                    end
                    S_READ: begin
                        if (rd_oor) begin
                            rd_x     <= '0;
                            rd_y     <= '0;
                            rd_err_r <= 1'b1;
                            state    <= S_RD_DONE;
                        end else begin
                            rd_err_r <= 1'b0;
                            wait_cnt <= '0;
                            state    <= S_RD_WAIT;
                        end
                    end
                    S_RD_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            rd_x  <= mem_x_q;
                            rd_y  <= mem_y_q;
                            state <= S_RD_DONE;
                        end else begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
                    end
                    S_RD_DONE: state <= S_IDLE;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_coord_mem_arbiter.sv
// Directed bench for coord_mem_arbiter with a one-cycle synchronous RAM model.
module tb_coord_mem_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       coll_done = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_x = '0;
    logic [7:0] wr_y = '0;
    logic       wr_ack;
    logic       rd_req = 1'b0;
    logic [7:0] rd_addr = '0;
    logic       rd_ack;
    logic       rd_valid;
    logic [7:0] rd_x;
    logic [7:0] rd_y;
    logic       rd_err;
    logic       table_ready;
    logic [8:0] coord_count;
    logic [7:0] mem_addr;
    logic       mem_wren;
    logic [7:0] mem_x_d;
    logic [7:0] mem_y_d;
    logic [7:0] mem_x_q = '0;
    logic [7:0] mem_y_q = '0;

    logic [7:0] ram_x [256];
    logic [7:0] ram_y [256];

    int errors = 0;
    int checks = 0;

    coord_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .clear(clear), .coll_done(coll_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .rd_x(rd_x), .rd_y(rd_y), .rd_err(rd_err), .table_ready(table_ready),
        .coord_count(coord_count), .mem_addr(mem_addr), .mem_wren(mem_wren),
        .mem_x_d(mem_x_d), .mem_y_d(mem_y_d), .mem_x_q(mem_x_q), .mem_y_q(mem_y_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) begin
            ram_x[mem_addr] <= mem_x_d;
            ram_y[mem_addr] <= mem_y_d;
        end
        mem_x_q <= ram_x[mem_addr];
        mem_y_q <= ram_y[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] x, input logic [7:0] y);
        int n;
        n = 0;
        wr_req = 1'b1; wr_addr = a; wr_x = x; wr_y = y;
        do begin tick(); n++; end while (!wr_ack && n < 10);
        check("wr_ack", wr_ack, 1);
        check("wr_mem_wren", mem_wren, 1);
        check("wr_mem_addr", mem_addr, a);
        check("wr_mem_x_d", mem_x_d, x);
        check("wr_mem_y_d", mem_y_d, y);
        wr_req = 1'b0;
        tick();
        check("wr_ack_pulse", wr_ack, 0);
        check("wr_wren_pulse", mem_wren, 0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] ex, input logic [7:0] ey,
                           input logic eerr);
        int n;
        n = 0;
        rd_req = 1'b1; rd_addr = a;
        do begin tick(); n++; end while (!rd_ack && n < 10);
        check("rd_ack", rd_ack, 1);
        check("rd_no_wren", mem_wren, 0);
        rd_req = 1'b0;
        tick();
        check("rd_ack_pulse", rd_ack, 0);
        if (!eerr) begin
            check("rd_valid_early", rd_valid, 0);
            tick();
        end
        check("rd_valid", rd_valid, 1);
        check("rd_err", rd_err, eerr);
        check("rd_x", rd_x, ex);
        check("rd_y", rd_y, ey);
        check("rd_wren_idle", mem_wren, 0);
        tick();
        check("rd_valid_pulse", rd_valid, 0);
    endtask

    initial begin
        int acks;
        int viol;
        int ng;
        int g [4];

        repeat (3) tick();
        check("rst_wr_ack", wr_ack, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_ready", table_ready, 0);
        check("rst_count", coord_count, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wren", mem_wren, 0);
        reset = 1'b1;
        tick();

        // Four sequential writes build a four-entry table.
        for (int i = 0; i < 4; i++)
            do_write(8'(i), 8'(10 + i), 8'(20 + i));
        check("count_4", coord_count, 4);

        // Reads stay parked until collection is declared done.
        rd_req = 1'b1; rd_addr = 8'd2;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_ack) acks++;
        end
        check("no_ack_before_ready", acks, 0);
        coll_done = 1'b1;
        tick();
        coll_done = 1'b0;
        check("ready_set", table_ready, 1);
        do_read(8'd2, 8'd12, 8'd22, 1'b0);

        // Read at the count boundary is out of range.
        do_read(8'd4, 8'd0, 8'd0, 1'b1);

        // Tied requests after reset alternate starting with the writer.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        coll_done = 1'b1;
        tick();
        coll_done = 1'b0;
        wr_req = 1'b1; wr_addr = 8'd0; wr_x = 8'd5; wr_y = 8'd6;
        rd_req = 1'b1; rd_addr = 8'd0;
        viol = 0; ng = 0;
        for (int i = 0; i < 4; i++) g[i] = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (wr_ack && rd_ack) viol++;
            if (mem_wren !== wr_ack) viol++;
            if (wr_ack && ng < 4) begin g[ng] = 1; ng++; end
            else if (rd_ack && ng < 4) begin g[ng] = 2; ng++; end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (5) tick();
        check("rr_no_overlap", viol, 0);
        check("rr_grant0_w", g[0], 1);
        check("rr_grant1_r", g[1], 2);
        check("rr_grant2_w", g[2], 1);
        check("rr_grant3_r", g[3], 2);

        // Top address saturates the count; clear then aborts an in-flight read.
        do_write(8'd255, 8'h77, 8'h88);
        check("count_256", coord_count, 256);
        rd_req = 1'b1; rd_addr = 8'd255;
        acks = 0;
        do begin tick(); acks++; end while (!rd_ack && acks < 10);
        check("clr_rd_ack", rd_ack, 1);
        rd_req = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (rd_valid) acks++;
            tick();
        end
        check("clr_no_valid", acks, 0);
        check("clr_count", coord_count, 0);
        check("clr_ready", table_ready, 0);

        // Reset mid-read clears outputs immediately.
        coll_done = 1'b1;
        tick();
        coll_done = 1'b0;
        do_write(8'd7, 8'h31, 8'h32);
        rd_req = 1'b1; rd_addr = 8'd7;
        acks = 0;
        do begin tick(); acks++; end while (!rd_ack && acks < 10);
        rd_req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_x", rd_x, 0);
        check("arst_count", coord_count, 0);
        check("arst_ready", table_ready, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_x_d", mem_x_d, 0);
        repeat (2) tick();
        check("arst_hold_valid", rd_valid, 0);
        reset = 1'b1;
        tick();
        do_write(8'd3, 8'h43, 8'h44);
        coll_done = 1'b1;
        tick();
        coll_done = 1'b0;
        do_read(8'd3, 8'h43, 8'h44, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
